div_unit: RTL



---
 rtl/div_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle.
// The quotient goes to LO and the remainder to HI.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    count;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  // The most negative value negates to itself. Read as unsigned, that is
  // the correct magnitude.
  always_comb begin
    a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
  end

  // The shifted remainder needs WIDTH+1 bits so that the compare does not
  // overflow. When it fits, the difference is below the divisor, so the
  // low WIDTH bits of the subtraction are exact.
  always_comb begin
    rem_sh  = {rem, dvd[WIDTH-1]};
    fits    = (rem_sh >= {1'b0, dvs});
    diff    = rem_sh[WIDTH-1:0] - dvs;
    rem_nxt = fits ? diff : rem_sh[WIDTH-1:0];
    dvd_nxt = {dvd[WIDTH-2:0], fits};
    q_fin   = sign_q ? -dvd_nxt : dvd_nxt;
    r_fin   = sign_r ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rem         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      count       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            sign_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r <= is_signed & a[WIDTH-1];
            dvs    <= b_mag;
            busy   <= 1'b1;
            if (b == '0) begin
              // Divide by zero skips iteration and reports the raw dividend.
              quotient    <= '1;
              remainder   <= a;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              rem   <= '0;
              dvd   <= a_mag;
              count <= CW'(WIDTH - 1);
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem <= rem_nxt;
          dvd <= dvd_nxt;
          if (count == '0) begin
            quotient    <= q_fin;
            remainder   <= r_fin;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
